mdu_sched: RTL and testbench

- Sequencer for the E-stage multiply/divide resource.
- Accepts one MDU operation per start pulse and runs a fixed-latency multiply or divide.
- Owns the HI/LO registers and raises busy while an operation is in flight.
- Generates the D-stage stall request that keeps MDU-dependent instructions out of E until HI/LO are valid.

---
 rtl/mdu_pkg.sv | 46 ++++
 rtl/mdu_sched_if.sv | 29 ++
 rtl/mdu_arith.sv | 54 +++++
 rtl/mdu_sched.sv | 106 ++++++++++
 tb/tb_mdu_sched.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared opcode/state encodings and default latencies for the MDU
// sequencer. Optional macro MDU_MADD_EN enables the madd/msub family.
package mdu_pkg;

    localparam int OP_W        = 4;
    localparam int MUL_LAT_DEF = 5;
    localparam int DIV_LAT_DEF = 10;
    localparam int CNT_W_DEF   = 4;

    typedef enum logic [OP_W-1:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MFHI  = 4'd7,
        OP_MFLO  = 4'd8,
        OP_MADD  = 4'd9,
        OP_MADDU = 4'd10,
        OP_MSUB  = 4'd11,
        OP_MSUBU = 4'd12
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    // Ops that occupy the unit for a fixed latency and write HI/LO at the end.
    function automatic logic is_long_op(input logic [OP_W-1:0] op);
        case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: return 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_div_op(input logic [OP_W-1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_sched_if.sv
// mdu_sched_if: E-stage request / HI-LO result bundle of the MDU sequencer.
interface mdu_sched_if;
    import mdu_pkg::*;

    logic            start;
    logic [OP_W-1:0] op;
    logic [31:0]     src_a;
    logic [31:0]     src_b;
    logic            mdu_in_d;
    logic            flush;
    logic            busy;
    logic            stall;
    logic [31:0]     hi;
    logic [31:0]     lo;
    logic [31:0]     mdu_out;
    logic            done;

    // Pipeline side drives the request, MDU returns status and HI/LO.
    modport master (
        output start, op, src_a, src_b, mdu_in_d, flush,
        input  busy, stall, hi, lo, mdu_out, done
    );

    modport slave (
        input  start, op, src_a, src_b, mdu_in_d, flush,
        output busy, stall, hi, lo, mdu_out, done
    );

endinterface

// File: rtl/mdu_arith.sv
// mdu_arith: combinational 64-bit result for mult/div (and madd family when
// MDU_MADD_EN is defined). Returns {hi, lo} unchanged for ops it does not own.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [OP_W-1:0] op,
    input  logic [31:0]     a,
    input  logic [31:0]     b,
    input  logic [31:0]     hi,
    input  logic [31:0]     lo,
    output logic [63:0]     res
);

    logic        signed_op;
    logic [63:0] ext_a, ext_b, prod;
    logic [31:0] abs_a, abs_b, div_b;
    logic [31:0] quo_u, rem_u, quo, rem;
    logic        neg_q, neg_r;

    // Multiply and divide datapaths; divide works on magnitudes so the
    // 0x80000000 / -1 case falls out as 0x80000000 rem 0 without special-casing.
    always_comb begin
        signed_op = (op == OP_MULT) || (op == OP_DIV) ||
                    (op == OP_MADD) || (op == OP_MSUB);
        ext_a = signed_op ? {{32{a[31]}}, a} : {32'h0, a};
        ext_b = signed_op ? {{32{b[31]}}, b} : {32'h0, b};
        prod  = ext_a * ext_b;

        abs_a = (signed_op && a[31]) ? (32'h0 - a) : a;
        abs_b = (signed_op && b[31]) ? (32'h0 - b) : b;
        div_b = (b == 32'h0) ? 32'h1 : abs_b;
        quo_u = abs_a / div_b;
        rem_u = abs_a % div_b;
        neg_q = signed_op && (a[31] ^ b[31]);
        neg_r = signed_op && a[31];
        quo   = neg_q ? (32'h0 - quo_u) : quo_u;
        rem   = neg_r ? (32'h0 - rem_u) : rem_u;
    end

    // Result select; a zero divisor leaves HI/LO as they were.
    always_comb begin
        res = {hi, lo};
        case (op)
            OP_MULT, OP_MULTU: res = prod;
            OP_DIV, OP_DIVU:   res = (b == 32'h0) ? {hi, lo} : {rem, quo};
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU: res = {hi, lo} + prod;
            OP_MSUB, OP_MSUBU: res = {hi, lo} - prod;
`endif
            default:           res = {hi, lo};
        endcase
    end

endmodule

// File: rtl/mdu_sched.sv
// mdu_sched: E-stage multiply/divide sequencer. Owns HI/LO, holds busy for a
// fixed latency per op and raises the D-stage stall for MDU-dependent
// instructions. Optional macro MDU_MADD_EN adds madd/maddu/msub/msubu.
module mdu_sched
    import mdu_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        reset,
    mdu_sched_if.slave  bus
);

    mdu_state_e  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [63:0] pend_q, pend_d;
    logic        done_q, done_d;
    logic        eff_start, long_op;
    logic [63:0] arith_res;

    assign eff_start = bus.start & ~bus.flush;
    assign long_op   = is_long_op(bus.op);

    mdu_arith u_arith (
        .op  (bus.op),
        .a   (bus.src_a),
        .b   (bus.src_b),
        .hi  (hi_q),
        .lo  (lo_q),
        .res (arith_res)
    );

    // Next-state: latch result at start, count down, commit on the last cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        pend_d  = pend_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (eff_start) begin
                    if (long_op) begin
                        pend_d  = arith_res;
                        cnt_d   = is_div_op(bus.op) ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
                        state_d = ST_RUN;
                    end else if (bus.op == OP_MTHI) begin
                        hi_d = bus.src_a;
                    end else if (bus.op == OP_MTLO) begin
                        lo_d = bus.src_a;
                    end
                end
            end
            ST_RUN: begin
                // Starts arriving here are illegal and deliberately ignored.
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = pend_q[63:32];
                    lo_d    = pend_q[31:0];
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register; reset aborts any in-flight op and clears HI/LO.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            pend_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
        end
    end

    // Read port for mfhi/mflo sees committed HI/LO only.
    always_comb begin
        case (bus.op)
            OP_MFHI: bus.mdu_out = hi_q;
            OP_MFLO: bus.mdu_out = lo_q;
            default: bus.mdu_out = 32'h0;
        endcase
    end

    assign bus.busy  = (state_q == ST_RUN);
    assign bus.stall = bus.mdu_in_d & (bus.busy | (eff_start & long_op));
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_mdu_sched.sv
// tb_mdu_sched: scoreboard bench for mdu_sched. Expected {hi,lo} are queued
// when an op is issued and compared when done pulses.
module tb_mdu_sched;
    import mdu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mdu_sched_if bus();

    mdu_sched #(.MUL_LAT(5), .DIV_LAT(10), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          n_tests  = 0;
    int          n_fail   = 0;
    int          done_cnt = 0;
    logic [63:0] sb[$];
    logic [63:0] sb_exp;

    // Scoreboard: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset === 1'b1 && bus.done === 1'b1) begin
            done_cnt++;
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_done: unexpected done, hi=%h lo=%h", bus.hi, bus.lo);
            end else begin
                sb_exp = sb.pop_front();
                if ({bus.hi, bus.lo} !== sb_exp) begin
                    n_fail++;
                    $display("FAIL sb_hilo: got %h_%h want %h_%h",
                             bus.hi, bus.lo, sb_exp[63:32], sb_exp[31:0]);
                end
            end
        end
    end

    // Protocol: no start may be accepted while an op is in flight.
    always @(posedge clk) begin
        if (reset === 1'b1)
            assert (!(bus.start && !bus.flush && bus.busy))
                else $error("start issued while busy");
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic drive_idle;
        bus.start    = 1'b0;
        bus.op       = OP_NONE;
        bus.src_a    = '0;
        bus.src_b    = '0;
        bus.flush    = 1'b0;
        bus.mdu_in_d = 1'b0;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.src_a = a;
        bus.src_b = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = OP_NONE;
    endtask

    // Counts busy cycles, bounded so a stuck unit cannot hang the run.
    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (bus.busy === 1'b1 && cycles < 64) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk);
        n_tests++;
        if ({bus.busy, bus.done, bus.stall, bus.hi, bus.lo} !== 67'h0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b stall=%b hi=%h lo=%h want all 0",
                     bus.busy, bus.done, bus.stall, bus.hi, bus.lo);
        end
        reset = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: busy=%b want 0", bus.busy);
        end
    endtask

    task automatic test_mult;
        int cyc, d0;
        d0 = done_cnt;
        sb.push_back(64'hFFFFFFFF_FFFFFFFA);
        issue(OP_MULT, 32'hFFFFFFFE, 32'd3);
        wait_idle(cyc);
        n_tests++;
        if (cyc != 5) begin
            n_fail++;
            $display("FAIL mult_lat: busy %0d cycles want 5", cyc);
        end
        @(negedge clk);
        n_tests++;
        if (done_cnt != d0 + 1 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL mult_done: pulses=%0d done=%b want 1 pulse", done_cnt - d0, bus.done);
        end
        sb.push_back(64'h00000002_FFFFFFFA);
        issue(OP_MULTU, 32'hFFFFFFFE, 32'd3);
        wait_idle(cyc);
        n_tests++;
        if (cyc != 5) begin
            n_fail++;
            $display("FAIL multu_lat: busy %0d cycles want 5", cyc);
        end
        @(negedge clk);
    endtask

    task automatic test_div;
        int cyc, d0;
        sb.push_back(64'hFFFFFFFF_FFFFFFFD);
        issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
        wait_idle(cyc);
        n_tests++;
        if (cyc != 10) begin
            n_fail++;
            $display("FAIL div_lat: busy %0d cycles want 10", cyc);
        end
        @(negedge clk);
        // Zero divisor: full latency, done pulses, HI/LO unchanged.
        d0 = done_cnt;
        sb.push_back(64'hFFFFFFFF_FFFFFFFD);
        issue(OP_DIVU, 32'd7, 32'd0);
        wait_idle(cyc);
        n_tests++;
        if (cyc != 10) begin
            n_fail++;
            $display("FAIL divz_lat: busy %0d cycles want 10", cyc);
        end
        @(negedge clk);
        n_tests++;
        if (done_cnt != d0 + 1) begin
            n_fail++;
            $display("FAIL divz_done: pulses=%0d want 1", done_cnt - d0);
        end
        sb.push_back(64'h00000000_80000000);
        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_idle(cyc);
        @(negedge clk);
    endtask

    task automatic test_stall;
        bus.mdu_in_d = 1'b1;
        sb.push_back(64'h00000000_00123450);
        bus.start = 1'b1;
        bus.op    = OP_MULT;
        bus.src_a = 32'h00012345;
        bus.src_b = 32'h00000010;
        #1;
        n_tests++;
        if (bus.stall !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_start: stall=%b want 1", bus.stall);
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = OP_NONE;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_tests++;
            if ({bus.busy, bus.stall} !== 2'b11) begin
                n_fail++;
                $display("FAIL stall_busy%0d: busy=%b stall=%b want 1 1", i + 1, bus.busy, bus.stall);
            end
            @(negedge clk);
        end
        #1;
        n_tests++;
        if ({bus.busy, bus.stall} !== 2'b00) begin
            n_fail++;
            $display("FAIL stall_drop: busy=%b stall=%b want 0 0", bus.busy, bus.stall);
        end
        bus.mdu_in_d = 1'b0;
        bus.start    = 1'b1;
        bus.op       = OP_MFLO;
        #1;
        n_tests++;
        if (bus.mdu_out !== 32'h00123450) begin
            n_fail++;
            $display("FAIL mflo_read: got %h want 00123450", bus.mdu_out);
        end
        @(negedge clk);
        drive_idle();
    endtask

    task automatic test_mt_mf;
        bus.mdu_in_d = 1'b1;
        bus.start    = 1'b1;
        bus.op       = OP_MTHI;
        bus.src_a    = 32'h12345678;
        #1;
        n_tests++;
        if (bus.stall !== 1'b0) begin
            n_fail++;
            $display("FAIL mthi_stall: stall=%b want 0", bus.stall);
        end
        @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'h12345678) begin
            n_fail++;
            $display("FAIL mthi_write: busy=%b hi=%h want 0 12345678", bus.busy, bus.hi);
        end
        bus.mdu_in_d = 1'b0;
        bus.op       = OP_MFHI;
        #1;
        n_tests++;
        if (bus.mdu_out !== 32'h12345678) begin
            n_fail++;
            $display("FAIL mfhi_read: got %h want 12345678", bus.mdu_out);
        end
        @(negedge clk);
        bus.op    = OP_MTLO;
        bus.src_a = 32'hCAFEF00D;
        @(negedge clk);
        bus.op = OP_MFLO;
        #1;
        n_tests++;
        if (bus.mdu_out !== 32'hCAFEF00D || bus.hi !== 32'h12345678) begin
            n_fail++;
            $display("FAIL mtlo_mflo: mdu_out=%h hi=%h want cafef00d 12345678", bus.mdu_out, bus.hi);
        end
        @(negedge clk);
        drive_idle();
    endtask

    task automatic test_flush;
        int d0;
        d0 = done_cnt;
        bus.mdu_in_d = 1'b1;
        bus.start    = 1'b1;
        bus.flush    = 1'b1;
        bus.op       = OP_MULT;
        bus.src_a    = 32'd3;
        bus.src_b    = 32'd5;
        #1;
        n_tests++;
        if (bus.stall !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_stall: stall=%b want 0", bus.stall);
        end
        @(negedge clk);
        drive_idle();
        repeat (6) @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b0 || {bus.hi, bus.lo} !== 64'h12345678_CAFEF00D || done_cnt != d0) begin
            n_fail++;
            $display("FAIL flush_nop: busy=%b hi=%h lo=%h pulses=%0d want 0 12345678 cafef00d 0",
                     bus.busy, bus.hi, bus.lo, done_cnt - d0);
        end
    endtask

    task automatic test_madd;
        int cyc, d0;
        issue(OP_MTHI, 32'h0, 32'h0);
        issue(OP_MTLO, 32'hFFFFFFFF, 32'h0);
`ifdef MDU_MADD_EN
        sb.push_back(64'h00000001_00000000);
        issue(OP_MADDU, 32'd1, 32'd1);
        wait_idle(cyc);
        n_tests++;
        if (cyc != 5) begin
            n_fail++;
            $display("FAIL maddu_lat: busy %0d cycles want 5", cyc);
        end
        @(negedge clk);
        sb.push_back(64'h00000000_FFFFFFFA);
        issue(OP_MSUB, 32'd2, 32'd3);
        wait_idle(cyc);
        n_tests++;
        if (cyc != 5) begin
            n_fail++;
            $display("FAIL msub_lat: busy %0d cycles want 5", cyc);
        end
        @(negedge clk);
`else
        d0 = done_cnt;
        bus.mdu_in_d = 1'b1;
        bus.start    = 1'b1;
        bus.op       = OP_MADDU;
        bus.src_a    = 32'd1;
        bus.src_b    = 32'd1;
        #1;
        n_tests++;
        if (bus.stall !== 1'b0) begin
            n_fail++;
            $display("FAIL maddu_stall: stall=%b want 0", bus.stall);
        end
        @(negedge clk);
        drive_idle();
        cyc = 0;
        repeat (6) begin
            if (bus.busy === 1'b1) cyc++;
            @(negedge clk);
        end
        n_tests++;
        if (cyc != 0 || {bus.hi, bus.lo} !== 64'h00000000_FFFFFFFF || done_cnt != d0) begin
            n_fail++;
            $display("FAIL maddu_off: busy_cycles=%0d hi=%h lo=%h want 0 00000000 ffffffff",
                     cyc, bus.hi, bus.lo);
        end
`endif
    endtask

    task automatic test_abort_reset;
        int cyc, d0;
        sb.push_back(64'h00000002_0000000E);
        issue(OP_DIV, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        sb.delete();
        d0 = done_cnt;
        n_tests++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
            n_fail++;
            $display("FAIL abort_state: busy=%b hi=%h lo=%h want 0 0 0", bus.busy, bus.hi, bus.lo);
        end
        repeat (12) @(negedge clk);
        n_tests++;
        if (done_cnt != d0) begin
            n_fail++;
            $display("FAIL abort_done: pulses=%0d want 0", done_cnt - d0);
        end
        sb.push_back(64'h00000000_0000002A);
        issue(OP_MULT, 32'd6, 32'd7);
        wait_idle(cyc);
        n_tests++;
        if (cyc != 5) begin
            n_fail++;
            $display("FAIL abort_mult_lat: busy %0d cycles want 5", cyc);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int cyc;
        logic [31:0] a, b;
        longint sp;
        for (int i = 0; i < 9; i++) begin
            a = $urandom;
            b = $urandom;
            if (b == 32'h0) b = 32'd1;
            case (i % 3)
                0: begin
                    sp = longint'($signed(a)) * longint'($signed(b));
                    sb.push_back(sp);
                    issue(OP_MULT, a, b);
                end
                1: begin
                    sb.push_back({a % b, a / b});
                    issue(OP_DIVU, a, b);
                end
                default: begin
                    if (b == 32'hFFFFFFFF) b = 32'd3;
                    sb.push_back({32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))});
                    issue(OP_DIV, a, b);
                end
            endcase
            wait_idle(cyc);
            n_tests++;
            if (cyc != ((i % 3 == 0) ? 5 : 10)) begin
                n_fail++;
                $display("FAIL b2b_lat%0d: busy %0d cycles", i, cyc);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_stall();
        test_mt_mf();
        test_flush();
        test_madd();
        test_abort_reset();
        test_back_to_back();
        repeat (2) @(negedge clk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d expectations left, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
